// File: rtl/keccak_pkg.sv
// Shared Keccak-256 constants and control types for the absorb datapath and permutation core.
package keccak_pkg;
  localparam int unsigned LANE_W     = 64;
  localparam int unsigned RATE_LANES = 17;
  localparam int unsigned RATE_BITS  = 1088;

  localparam logic [7:0] DS_KECCAK = 8'h01;
  localparam logic [7:0] DS_SHA3   = 8'h06;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PADBLK
  } state_e;
endpackage

// File: rtl/keccak_lane_pad.sv
// Final-lane padding: keeps the first n bytes, puts the domain byte at byte n, zeroes the rest.
module keccak_lane_pad #(
  parameter int unsigned LANE_W  = 64,
  parameter logic [7:0]  DS_BYTE = 8'h01
) (
  input  logic [LANE_W-1:0] lane_i,
  input  logic [3:0]        nbytes_i,
  output logic [LANE_W-1:0] lane_o,
  output logic              full_o
);
  import keccak_pkg::*;

  localparam int unsigned NB = LANE_W / 8;

  int unsigned n;

  always_comb begin
    n = 32'(nbytes_i);
    if (n > NB) n = NB;
    full_o = (n == NB);
    lane_o = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      if (k < n)       lane_o[8*k +: 8] = lane_i[8*k +: 8];
      else if (k == n) lane_o[8*k +: 8] = DS_BYTE;
    end
  end
endmodule

// File: rtl/keccak_pad_absorber.sv
// Collects message lanes into padded rate blocks and hands them to the permutation stage.
module keccak_pad_absorber #(
  parameter int unsigned RATE_LANES = keccak_pkg::RATE_LANES,
  parameter int unsigned LANE_W     = keccak_pkg::LANE_W,
  parameter logic [7:0]  DS_BYTE    = keccak_pkg::DS_KECCAK
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANE_W-1:0]            in_data,
  input  logic [3:0]                   in_bytes,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [RATE_LANES*LANE_W-1:0] blk_data,
  output logic                         blk_last,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic                         busy
);
  import keccak_pkg::*;

  localparam int unsigned BW = RATE_LANES * LANE_W;
  localparam int unsigned CW = $clog2(RATE_LANES);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_LANES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   lane_cnt_q, lane_cnt_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic            last_q, last_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic            rdy_q;
  logic [LANE_W-1:0] pad_lane;
  logic            pad_full;

  keccak_lane_pad #(
    .LANE_W (LANE_W),
    .DS_BYTE(DS_BYTE)
  ) u_lane_pad (
    .lane_i  (in_data),
    .nbytes_i(in_bytes),
    .lane_o  (pad_lane),
    .full_o  (pad_full)
  );

  assign in_ready  = rdy_q && (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_last  = last_q;
  assign busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    buf_d      = buf_q;
    last_d     = last_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    unique case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          busy_d = 1'b1;
          for (int unsigned i = 0; i < RATE_LANES; i++) begin
            if (32'(lane_cnt_q) == i) buf_d[i*LANE_W +: LANE_W] = in_last ? pad_lane : in_data;
          end
          // A full final lane pushes the domain byte into the next lane of the same block.
          for (int unsigned i = 1; i < RATE_LANES; i++) begin
            if (in_last && pad_full && (32'(lane_cnt_q) == i - 1)) buf_d[i*LANE_W +: 8] = DS_BYTE;
          end
          if (in_last) begin
            lane_cnt_d = '0;
            state_d    = EMIT;
            if (pad_full && (lane_cnt_q == LAST_IDX)) begin
              last_d = 1'b0;
              pend_d = 1'b1;
            end else begin
              last_d = 1'b1;
              buf_d[BW-1 -: 8] = buf_d[BW-1 -: 8] | PAD_END;
            end
          end else if (lane_cnt_q == LAST_IDX) begin
            lane_cnt_d = '0;
            last_d     = 1'b0;
            state_d    = EMIT;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          last_d = 1'b0;
          if (last_q) busy_d = 1'b0;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = PADBLK;
          end else begin
            state_d = FILL;
          end
        end
      end
      PADBLK: begin
        buf_d            = '0;
        buf_d[7:0]       = DS_BYTE;
        buf_d[BW-1 -: 8] = PAD_END;
        last_d           = 1'b1;
        state_d          = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      lane_cnt_q <= '0;
      buf_q      <= '0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      buf_q      <= buf_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      rdy_q      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_keccak_pad_absorber.sv
// Directed bench for keccak_pad_absorber: padding corner cases, backpressure and async reset.
module tb_keccak_pad_absorber;
  localparam int unsigned BW = 17 * 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   in_data;
  logic [3:0]    in_bytes;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] blk_data;
  logic          blk_last;
  logic          blk_valid;
  logic          blk_ready;
  logic          busy;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  keccak_pad_absorber #(
    .RATE_LANES(17),
    .LANE_W    (64),
    .DS_BYTE   (8'h01)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_bytes (in_bytes),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .blk_data (blk_data),
    .blk_last (blk_last),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] exp);
    int unsigned bad;
    logic [BW-1:0] obs;
    obs = blk_data;
    bad = 0;
    for (int unsigned i = 0; i < 17; i++) begin
      if (obs[i*64 +: 64] !== exp[i*64 +: 64]) begin
        bad = i;
        break;
      end
    end
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: lane %0d observed %h expected %h", tag, bad, obs[bad*64 +: 64], exp[bad*64 +: 64]);
    end
  endtask

  function automatic logic [63:0] pat(input int unsigned i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {8{b}};
  endfunction

  function automatic logic [BW-1:0] pat_block(input int unsigned nl);
    logic [BW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < nl; i++) r[i*64 +: 64] = pat(i);
    return r;
  endfunction

  task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int unsigned w;
    w = 0;
    in_data  = d;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
  endtask

  task automatic consume();
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
  endtask

  logic [BW-1:0] exp_blk;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_bytes  = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_last", 64'(blk_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk_blk("rst_blk_data", '0);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("rst_rel_in_ready_high", 64'(in_ready), 64'd1);

    // Empty message
    send(64'hDEAD_BEEF_CAFE_F00D, 4'd0, 1'b1);
    chk("empty_valid", 64'(blk_valid), 64'd1);
    chk("empty_last", 64'(blk_last), 64'd1);
    chk("empty_busy", 64'(busy), 64'd1);
    exp_blk = '0;
    exp_blk[7:0] = 8'h01;
    exp_blk[1087] = 1'b1;
    chk_blk("empty_data", exp_blk);
    consume();
    chk("empty_post_valid", 64'(blk_valid), 64'd0);
    chk("empty_post_ready", 64'(in_ready), 64'd1);
    chk("empty_post_busy", 64'(busy), 64'd0);

    // "abc" with garbage upper bytes, then 5 cycles of backpressure
    send(64'hFFFF_FFFF_FF63_6261, 4'd3, 1'b1);
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000_0000_0163_6261;
    exp_blk[1087:1080] = 8'h80;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(blk_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk_blk("bp_data", exp_blk);
      tick();
    end
    chk("abc_last", 64'(blk_last), 64'd1);
    consume();
    chk("abc_post_valid", 64'(blk_valid), 64'd0);
    chk("abc_post_ready", 64'(in_ready), 64'd1);

    // 135 bytes: DS and final pad share byte 135
    for (int unsigned i = 0; i < 16; i++) send(pat(i), 4'd8, 1'b0);
    chk("m135_not_early", 64'(blk_valid), 64'd0);
    send(pat(16), 4'd7, 1'b1);
    exp_blk = pat_block(16);
    exp_blk[16*64 +: 64] = 64'h8111_1111_1111_1111;
    chk_blk("m135_data", exp_blk);
    chk("m135_top", 64'(blk_data[1087:1080]), 64'h81);
    chk("m135_last", 64'(blk_last), 64'd1);
    consume();
    chk("m135_busy", 64'(busy), 64'd0);

    // 136 bytes: full data block, then a separate pad block
    for (int unsigned i = 0; i < 16; i++) send(pat(i), 4'd8, 1'b0);
    send(pat(16), 4'd8, 1'b1);
    chk("m136_b1_valid", 64'(blk_valid), 64'd1);
    chk("m136_b1_last", 64'(blk_last), 64'd0);
    chk_blk("m136_b1_data", pat_block(17));
    consume();
    chk("m136_padblk_valid", 64'(blk_valid), 64'd0);
    chk("m136_padblk_ready", 64'(in_ready), 64'd0);
    chk("m136_padblk_busy", 64'(busy), 64'd1);
    tick();
    exp_blk = '0;
    exp_blk[7:0] = 8'h01;
    exp_blk[1087:1080] = 8'h80;
    chk("m136_b2_valid", 64'(blk_valid), 64'd1);
    chk("m136_b2_last", 64'(blk_last), 64'd1);
    chk_blk("m136_b2_data", exp_blk);
    consume();
    chk("m136_busy", 64'(busy), 64'd0);
    chk("m136_post_ready", 64'(in_ready), 64'd1);

    // 19 lanes: non-last wrap at lane 16, then full last lane with in_bytes clamped from 15
    for (int unsigned i = 0; i < 17; i++) send(pat(i), 4'd8, 1'b0);
    chk("m19_b1_valid", 64'(blk_valid), 64'd1);
    chk("m19_b1_last", 64'(blk_last), 64'd0);
    chk_blk("m19_b1_data", pat_block(17));
    consume();
    chk("m19_mid_busy", 64'(busy), 64'd1);
    send(pat(17), 4'd8, 1'b0);
    send(pat(18), 4'd15, 1'b1);
    exp_blk = '0;
    exp_blk[63:0]    = 64'h1212_1212_1212_1212;
    exp_blk[127:64]  = 64'h1313_1313_1313_1313;
    exp_blk[135:128] = 8'h01;
    exp_blk[1087:1080] = 8'h80;
    chk_blk("m19_b2_data", exp_blk);
    chk("m19_b2_last", 64'(blk_last), 64'd1);
    consume();

    // Async reset mid-fill, then a clean "abc"
    for (int unsigned i = 0; i < 9; i++) send(pat(i), 4'd8, 1'b0);
    chk("midrst_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_valid", 64'(blk_valid), 64'd0);
    chk_blk("midrst_data", '0);
    tick();
    rst = 1'b0;
    tick();
    send(64'hFFFF_FFFF_FF63_6261, 4'd3, 1'b1);
    exp_blk = '0;
    exp_blk[63:0] = 64'h0000_0000_0163_6261;
    exp_blk[1087:1080] = 8'h80;
    chk_blk("postrst_abc_data", exp_blk);
    chk("postrst_abc_last", 64'(blk_last), 64'd1);
    consume();
    chk("postrst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
